dmem_port_arbiter: RTL and testbench

Shares the single data-memory port between the CPU MEM stage and the CGRA load/store unit, and generates the pipeline-wide `Stall` that freezes the stage registers (MEM/WB included) while a CPU access is pending. Arbitration is round-robin across requesters, with one memory access outstanding at a time and a fixed memory latency. It sits between the MEM stage, the CGRA LSU and the data memory.

---
 rtl/dmem_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: shares one memory port between the CPU MEM stage
// and the CGRA load/store unit, and raises the pipeline stall for CPU accesses.
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   cpu_req_i/we_i/addr_i/wdata_i  MEM-stage access (held while stall_o is high)
//   cpu_rdata_o                  registered CPU load data
//   stall_o                      pipeline-wide stall
//   cgra_req_i/we_i/addr_i/wdata_i CGRA access (held until cgra_gnt_o)
//   cgra_gnt_o, cgra_ack_o       issue pulse, completion pulse
//   cgra_rdata_o                 registered CGRA load data
//   mem_req_o/we_o/addr_o/wdata_o  memory issue strobe and command
//   mem_rdata_i                  memory data, valid MEM_LATENCY cycles after issue
//
// MEM_LATENCY must be at least 1.

module dmem_port_arbiter #(
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    output logic [31:0] cpu_rdata_o,
    output logic        stall_o,

    input  logic        cgra_req_i,
    input  logic        cgra_we_i,
    input  logic [31:0] cgra_addr_i,
    input  logic [31:0] cgra_wdata_i,
    output logic        cgra_gnt_o,
    output logic        cgra_ack_o,
    output logic [31:0] cgra_rdata_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam int CW = $clog2(MEM_LATENCY + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LATENCY);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    localparam logic OWN_CPU  = 1'b0;
    localparam logic OWN_CGRA = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q,  last_d;
    logic          we_q,    we_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [31:0]   cpu_rdata_q;
    logic [31:0]   cgra_rdata_q;

    logic          issue;
    logic          gnt_cgra;
    logic          capture;
    logic          cpu_done;

    // Round-robin pick: on a tie the requester that did not win last time
    // gets the port.
    always_comb begin
        issue    = 1'b0;
        gnt_cgra = 1'b0;
        if (state_q == IDLE) begin
            unique case ({cpu_req_i, cgra_req_i})
                2'b10: begin
                    issue = 1'b1;
                end
                2'b01: begin
                    issue    = 1'b1;
                    gnt_cgra = 1'b1;
                end
                2'b11: begin
                    issue    = 1'b1;
                    gnt_cgra = (last_q == OWN_CPU);
                end
                default: begin
                    issue = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d = BUSY;
                    owner_d = gnt_cgra ? OWN_CGRA : OWN_CPU;
                    last_d  = gnt_cgra ? OWN_CGRA : OWN_CPU;
                    we_d    = gnt_cgra ? cgra_we_i : cpu_we_i;
                    cnt_d   = CNT_LOAD;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_LAST;
                if (cnt_q == CNT_LAST) begin
                    // Data lands on the final wait cycle; stores keep the
                    // previous load value visible.
                    capture = ~we_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= OWN_CPU;
            last_q  <= OWN_CGRA;
            we_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cpu_rdata_q  <= '0;
            cgra_rdata_q <= '0;
        end else if (capture) begin
            if (owner_q == OWN_CPU) begin
                cpu_rdata_q <= mem_rdata_i;
            end else begin
                cgra_rdata_q <= mem_rdata_i;
            end
        end
    end

    // The CPU request seen in its own DONE cycle is the completing
    // instruction, so the stall drops there and the pipeline advances.
    assign cpu_done = (state_q == DONE) && (owner_q == OWN_CPU);

    assign stall_o    = ~rst_i & cpu_req_i & ~cpu_done;
    assign cgra_ack_o = ~rst_i & (state_q == DONE) & (owner_q == OWN_CGRA);
    assign cgra_gnt_o = ~rst_i & issue & gnt_cgra;

    assign mem_req_o   = ~rst_i & issue;
    assign mem_we_o    = mem_req_o & (gnt_cgra ? cgra_we_i : cpu_we_i);
    assign mem_addr_o  = mem_req_o ? (gnt_cgra ? cgra_addr_i : cpu_addr_i)
                                   : 32'h0;
    assign mem_wdata_o = mem_req_o ? (gnt_cgra ? cgra_wdata_i : cpu_wdata_i)
                                   : 32'h0;

    assign cpu_rdata_o  = cpu_rdata_q;
    assign cgra_rdata_o = cgra_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: scoreboard queues fed by the
// requester drivers, drained by a cycle-level reference monitor.

module tb_dmem_port_arbiter;

    localparam int L = 2;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        rst_i;
    logic        cpu_req_i, cpu_we_i;
    logic [31:0] cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
    logic        stall_o;
    logic        cgra_req_i, cgra_we_i;
    logic [31:0] cgra_addr_i, cgra_wdata_i, cgra_rdata_o;
    logic        cgra_gnt_o, cgra_ack_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;

    // second instance, MEM_LATENCY = 1
    logic        c1_req, c1_we;
    logic [31:0] c1_addr, c1_wdata, c1_rdata;
    logic        stall1;
    logic        g1_req, g1_we;
    logic [31:0] g1_addr, g1_wdata, g1_rdata;
    logic        g1_gnt, g1_ack;
    logic        m1_req, m1_we;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;

    dmem_port_arbiter #(.MEM_LATENCY(L)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i),
        .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
        .cpu_rdata_o(cpu_rdata_o), .stall_o(stall_o),
        .cgra_req_i(cgra_req_i), .cgra_we_i(cgra_we_i),
        .cgra_addr_i(cgra_addr_i), .cgra_wdata_i(cgra_wdata_i),
        .cgra_gnt_o(cgra_gnt_o), .cgra_ack_o(cgra_ack_o),
        .cgra_rdata_o(cgra_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i)
    );

    dmem_port_arbiter #(.MEM_LATENCY(1)) dut1 (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_req_i(c1_req), .cpu_we_i(c1_we),
        .cpu_addr_i(c1_addr), .cpu_wdata_i(c1_wdata),
        .cpu_rdata_o(c1_rdata), .stall_o(stall1),
        .cgra_req_i(g1_req), .cgra_we_i(g1_we),
        .cgra_addr_i(g1_addr), .cgra_wdata_i(g1_wdata),
        .cgra_gnt_o(g1_gnt), .cgra_ack_o(g1_ack),
        .cgra_rdata_o(g1_rdata),
        .mem_req_o(m1_req), .mem_we_o(m1_we),
        .mem_addr_o(m1_addr), .mem_wdata_o(m1_wdata),
        .mem_rdata_i(m1_rdata)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [159:0] act,
                       input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // ---------------- memory model ----------------
    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] ref_mem   [logic [31:0]];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_model.exists(a) ? mem_model[a] : dflt(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    logic        rd_pend = 1'b0;
    int          rd_due = 0;
    logic [31:0] rd_data = '0;

    always begin
        @(posedge clk_i);
        cyc++;
        #1;
        mem_rdata_i = (rd_pend && cyc == rd_due) ? rd_data : $urandom;
    end

    always @(negedge clk_i) begin
        if (mem_req_o) begin
            if (mem_we_o) begin
                mem_model[mem_addr_o] = mem_wdata_o;
            end else begin
                rd_pend = 1'b1;
                rd_due  = cyc + L;
                rd_data = mem_rd(mem_addr_o);
            end
        end
    end

    // ---------------- drivers + scoreboard feed ----------------
    logic [31:0] cpu_q[$];
    logic [31:0] cgra_q[$];
    logic [31:0] cpu_prev = '0;
    logic [31:0] cgra_prev = '0;

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic cpu_access(input logic we, input logic [31:0] a,
                              input logic [31:0] d);
        int n;
        if (we) ref_mem[a] = d;
        else cpu_prev = ref_rd(a);
        cpu_q.push_back(cpu_prev);
        cpu_req_i = 1'b1; cpu_we_i = we;
        cpu_addr_i = a; cpu_wdata_i = d;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while ((stall_o || rst_i) && n < 100);
        chk("cpu_wait_timeout", n >= 100, 0);
        @(posedge clk_i);
        #1;
        cpu_req_i = 1'b0; cpu_we_i = 1'b0;
        cpu_addr_i = '0; cpu_wdata_i = '0;
    endtask

    task automatic cgra_access(input logic we, input logic [31:0] a,
                               input logic [31:0] d);
        int n;
        if (we) ref_mem[a] = d;
        else cgra_prev = ref_rd(a);
        cgra_q.push_back(cgra_prev);
        cgra_req_i = 1'b1; cgra_we_i = we;
        cgra_addr_i = a; cgra_wdata_i = d;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!cgra_gnt_o && n < 100);
        chk("cgra_gnt_timeout", n >= 100, 0);
        @(posedge clk_i);
        #1;
        cgra_req_i = 1'b0; cgra_we_i = 1'b0;
        cgra_addr_i = '0; cgra_wdata_i = '0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        cpu_prev = '0;
        cgra_prev = '0;
        idle(2);
        rst_i = 1'b0;
    endtask

    // ---------------- reference monitor ----------------
    logic        have_iss = 1'b0;
    logic        last_cgra = 1'b1;
    logic        cpu_v = 1'b0, cgra_v = 1'b0;
    int          last_iss = 0, cpu_iss = 0, cgra_iss = 0;
    logic [31:0] cpu_hold = '0, cgra_hold = '0;
    logic        ei, ec, edc, ea;
    logic [31:0] e;

    always @(negedge clk_i) begin
        if (rst_i) begin
            chk("reset_outs",
                {cpu_rdata_o, cgra_rdata_o, stall_o, cgra_gnt_o, cgra_ack_o,
                 mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}, '0);
            have_iss = 1'b0; last_cgra = 1'b1;
            cpu_v = 1'b0; cgra_v = 1'b0;
            cpu_hold = '0; cgra_hold = '0;
        end else begin
            ei = (!have_iss || cyc >= last_iss + L + 2)
                 && (cpu_req_i || cgra_req_i);
            ec = ei && cgra_req_i && (!cpu_req_i || !last_cgra);
            chk("mem_req", mem_req_o, ei);
            chk("cgra_gnt", cgra_gnt_o, ec);
            if (ei)
                chk("mem_bus", {mem_we_o, mem_addr_o, mem_wdata_o},
                    ec ? {cgra_we_i, cgra_addr_i, cgra_wdata_i}
                       : {cpu_we_i, cpu_addr_i, cpu_wdata_i});
            else
                chk("mem_idle", {mem_we_o, mem_addr_o, mem_wdata_o}, '0);
            edc = cpu_v && cyc == cpu_iss + L + 1;
            ea  = cgra_v && cyc == cgra_iss + L + 1;
            chk("stall", stall_o, cpu_req_i && !edc);
            chk("cgra_ack", cgra_ack_o, ea);
            if (edc) begin
                chk("cpu_q_nonempty", cpu_q.size() > 0, 1);
                if (cpu_q.size() > 0) begin
                    e = cpu_q.pop_front();
                    cpu_hold = e;
                    chk("cpu_rdata", cpu_rdata_o, e);
                end
            end else begin
                chk("cpu_rdata_hold", cpu_rdata_o, cpu_hold);
            end
            if (ea) begin
                chk("cgra_q_nonempty", cgra_q.size() > 0, 1);
                if (cgra_q.size() > 0) begin
                    e = cgra_q.pop_front();
                    cgra_hold = e;
                    chk("cgra_rdata", cgra_rdata_o, e);
                end
            end else begin
                chk("cgra_rdata_hold", cgra_rdata_o, cgra_hold);
            end
            if (ei) begin
                have_iss = 1'b1;
                last_iss = cyc;
                last_cgra = ec;
                if (ec) begin
                    cgra_v = 1'b1;
                    cgra_iss = cyc;
                end else begin
                    cpu_v = 1'b1;
                    cpu_iss = cyc;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    logic        w;
    logic [31:0] a;

    initial begin
        rst_i = 1'b1;
        cpu_req_i = 0; cpu_we_i = 0; cpu_addr_i = '0; cpu_wdata_i = '0;
        cgra_req_i = 0; cgra_we_i = 0; cgra_addr_i = '0; cgra_wdata_i = '0;
        c1_req = 0; c1_we = 0; c1_addr = '0; c1_wdata = '0;
        g1_req = 0; g1_we = 0; g1_addr = '0; g1_wdata = '0;
        m1_rdata = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("l1_reset_outs",
            {c1_rdata, g1_rdata, stall1, g1_gnt, g1_ack,
             m1_req, m1_we, m1_addr, m1_wdata}, '0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // MEM_LATENCY = 1 CPU load
        idle(1);
        c1_req = 1'b1; c1_addr = 32'h40;
        @(negedge clk_i);
        chk("l1_issue", {m1_req, stall1}, 2'b11);
        @(posedge clk_i);
        #1;
        m1_rdata = 32'h0000CAFE;
        @(negedge clk_i);
        chk("l1_busy_stall", stall1, 1);
        @(posedge clk_i);
        #1;
        m1_rdata = $urandom;
        @(negedge clk_i);
        chk("l1_done_stall", stall1, 0);
        chk("l1_rdata", c1_rdata, 32'h0000CAFE);
        @(posedge clk_i);
        #1;
        c1_req = 1'b0; c1_addr = '0;
        idle(2);

        // lone CPU load
        mem_model[32'h100] = 32'hDEADBEEF;
        ref_mem[32'h100] = 32'hDEADBEEF;
        cpu_access(1'b0, 32'h100, 32'h0);
        chk("t1_rdata", cpu_rdata_o, 32'hDEADBEEF);
        idle(3);

        // simultaneous requests right after reset
        do_reset();
        fork
            cpu_access(1'b0, 32'h104, 32'h0);
            cgra_access(1'b0, 32'h204, 32'h0);
        join
        idle(8);

        // CGRA store in flight, CPU load one cycle later
        fork
            cgra_access(1'b1, 32'h208, 32'h12345678);
            begin
                idle(1);
                cpu_access(1'b0, 32'h108, 32'h0);
            end
        join
        idle(8);

        // both held continuously
        fork
            begin
                for (int i = 0; i < 3; i++)
                    cpu_access(1'b0, 32'h110 + 32'(4 * i), 32'h0);
            end
            begin
                for (int i = 0; i < 3; i++)
                    cgra_access(1'(i), 32'h210 + 32'(4 * i), $urandom);
            end
        join
        idle(8);

        // reset in the middle of a CPU load
        fork
            cpu_access(1'b0, 32'h10C, 32'h0);
            begin
                idle(1);
                rst_i = 1'b1;
                idle(2);
                rst_i = 1'b0;
                cgra_prev = '0;
                @(negedge clk_i);
                chk("rst_no_capture", cpu_rdata_o, 32'h0);
                chk("rst_reissue", mem_req_o, 1);
            end
        join
        idle(8);

        // random traffic
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    w = 1'($urandom_range(0, 1));
                    a = 32'(4 * $urandom_range(0, 127));
                    cpu_access(w, a, $urandom);
                    idle($urandom_range(0, 3));
                end
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    cgra_access(1'($urandom_range(0, 1)),
                                32'h200 + 32'(4 * $urandom_range(0, 127)),
                                $urandom);
                    idle($urandom_range(0, 3));
                end
            end
        join
        idle(10);

        chk("cpu_q_drained", cpu_q.size(), 0);
        chk("cgra_q_drained", cgra_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
